// File: rtl/jump_pkg.sv
// Shared definitions for the jump game front end and VGA_Display.
//   state_t : 2-bit encoding of the press/charge controller FSM.
//   dir_t   : next-platform direction codes; VGA_Display decodes these.
//   CHARGE_W_DEF : default width of the charge count and jump distance.
package jump_pkg;

  localparam int CHARGE_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_CHARGING = 2'b01,
    ST_JUMP     = 2'b10,
    ST_LOCKED   = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability-counter debouncer for a push-button.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   raw      : asynchronous button level
//   level    : debounced level
//   rise     : one-cycle pulse in the first cycle level reads 1
//   fall     : one-cycle pulse in the first cycle level reads 0
// Latency from a clean raw edge to level is 2 + DB_LIMIT cycles.
module btn_debounce #(
  parameter int DB_LIMIT = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int DB_W = (DB_LIMIT > 1) ? $clog2(DB_LIMIT) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_LIMIT - 1);

  logic            sync_p0;
  logic            sync_p1;
  logic            level_q;
  logic [DB_W-1:0] db_cnt;

  // Stage p0/p1: metastability guard on the asynchronous input
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: level only follows sync_p1 after DB_LIMIT consecutive
  // disagreeing cycles; any agreement restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt  <= '0;
      level   <= 1'b0;
      level_q <= 1'b0;
    end else begin
      level_q <= level;
      if (sync_p1 == level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        level  <= sync_p1;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  assign rise = level & ~level_q;
  assign fall = ~level & level_q;

endmodule

// File: rtl/press_charge_ctrl.sv
// Press/charge front end of the jump game.
// Debounces the button, measures hold time in TICK_DIV-cycle charge units
// (saturating at CHARGE_MAX), latches a pseudo-random direction when a
// press starts, and raises one jump request per completed press until the
// display acknowledges it.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   btn_raw     : asynchronous button level, 1 = pressed
//   game_end    : game over level from display, locks the controller
//   jump_ack    : one-cycle pulse consuming the pending jump
//   btn_level   : debounced button level
//   is_pressing : 1 while charging
//   press_time  : live charge count
//   position    : direction latched at press start (jump_pkg::dir_t)
//   jump_valid  : jump request pending
//   jump_dist   : charge of the pending jump
module press_charge_ctrl
  import jump_pkg::*;
#(
  parameter int          DB_LIMIT   = 1_000_000,
  parameter int          TICK_DIV   = 5_000_000,
  parameter int          CHARGE_MAX = 15,
  parameter int          CHARGE_W   = CHARGE_W_DEF,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_raw,
  input  logic                game_end,
  input  logic                jump_ack,
  output logic                btn_level,
  output logic                is_pressing,
  output logic [CHARGE_W-1:0] press_time,
  output logic [1:0]          position,
  output logic                jump_valid,
  output logic [CHARGE_W-1:0] jump_dist
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [CHARGE_W-1:0] CMAX      = CHARGE_W'(CHARGE_MAX);

  state_t              state;
  state_t              state_nxt;
  logic                press_evt;
  logic                release_evt;
  logic [TICK_W-1:0]   tick_cnt;
  logic                tick_wrap;
  logic [CHARGE_W-1:0] charge_nxt;
  logic [15:0]         lfsr;
  dir_t                pos_q;

  function automatic logic [CHARGE_W-1:0] sat_inc(input logic [CHARGE_W-1:0] v);
    if (v >= CMAX) return CMAX;
    return v + CHARGE_W'(1);
  endfunction

  // Fibonacci LFSR, taps 16,14,13,11; a non-zero seed keeps it off all-zero.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  btn_debounce #(
    .DB_LIMIT (DB_LIMIT)
  ) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_raw),
    .level (btn_level),
    .rise  (press_evt),
    .fall  (release_evt)
  );

  assign tick_wrap  = (tick_cnt == TICK_LAST);
  // A release on a wrap cycle still collects that final unit.
  assign charge_nxt = tick_wrap ? sat_inc(press_time) : press_time;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (game_end) begin
      state_nxt = ST_LOCKED;
    end else begin
      unique case (state)
        ST_IDLE:     if (press_evt) state_nxt = ST_CHARGING;
        ST_CHARGING: if (release_evt)
                       state_nxt = (charge_nxt == '0) ? ST_IDLE : ST_JUMP;
        ST_JUMP:     if (jump_ack) state_nxt = ST_IDLE;
        ST_LOCKED:   state_nxt = ST_LOCKED;
        default:     state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    is_pressing = (state == ST_CHARGING);
    jump_valid  = (state == ST_JUMP);
  end

  // Charge datapath, direction latch and free-running LFSR
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr       <= LFSR_SEED;
      tick_cnt   <= '0;
      press_time <= '0;
      jump_dist  <= '0;
      pos_q      <= DIR_UP;
    end else begin
      lfsr <= lfsr_step(lfsr);
      if (game_end) begin
        tick_cnt   <= '0;
        press_time <= '0;
        jump_dist  <= '0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (press_evt) begin
              tick_cnt   <= '0;
              press_time <= '0;
              pos_q      <= dir_t'(lfsr[1:0]);
            end
          end
          ST_CHARGING: begin
            tick_cnt   <= tick_wrap ? '0 : tick_cnt + TICK_W'(1);
            press_time <= charge_nxt;
            if (release_evt && (charge_nxt != '0)) jump_dist <= charge_nxt;
          end
          default: ;
        endcase
      end
    end
  end

  assign position = pos_q;

endmodule
